// File: rtl/ddr_cmd_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ddr_cmd_responder                                            |
// | Description : DRAM-side DDR4 command decoder, bank/MRS tracker and burst   |
// |               store. Optional C/A parity check under DDR_RESP_PARITY_EN.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ddr_cmd_responder #(
    parameter int DATA_W    = 64,
    parameter int COL_IDX_W = 6,
    parameter int MEM_AW    = 10,
    parameter int PEND_D    = 4
) (
    input  logic              clock_t,
    input  logic              reset_n,
    input  logic              cs_n,
    input  logic              act_n,
    input  logic              ras_n,
    input  logic              cas_n,
    input  logic              we_n,
    input  logic [1:0]        bg,
    input  logic [1:0]        ba,
    input  logic [17:0]       addr,
    input  logic              par,
    input  logic [DATA_W-1:0] dq_in,
    output logic [DATA_W-1:0] dq_out,
    output logic              dq_oe,
    output logic              rd_pre,
    output logic [4:0]        cl,
    output logic [4:0]        cwl,
    output logic [4:0]        al,
    output logic [3:0]        bl,
    output logic [3:0]        err,
    output logic              alert_n
);

    localparam int c_COLH_W = COL_IDX_W - 3;
    localparam int c_PTR_W  = (PEND_D > 1) ? $clog2(PEND_D) : 1;
    localparam int c_QN_W   = $clog2(PEND_D + 1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(PEND_D - 1);
    localparam logic [c_QN_W-1:0]  c_QN_FULL  = c_QN_W'(PEND_D);

    typedef struct packed {
        logic [15:0]         due;
        logic                rw;     // 1 = read
        logic [1:0]          bg;
        logic [1:0]          ba;
        logic [c_COLH_W-1:0] col;
        logic                bl8;
    } pend_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRE   = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    logic                w_cmd_en;
    logic [3:0]          w_pins;
    logic [3:0]          w_bank;
    logic                w_act, w_mrs, w_ref, w_pre, w_wr, w_rd, w_cas;
    logic [15:0]         r_cnt;
    logic [15:0]         r_open;
    logic [17:0]         r_row [16];
    logic [17:0]         w_cas_row;
    logic [4:0]          r_cl, r_cwl, r_al;
    logic                r_bl8, r_rpre, r_wpre;
    logic [3:0]          r_err;
    pend_t               r_q [PEND_D];
    logic [c_PTR_W-1:0]  r_wp, r_rp;
    logic [c_QN_W-1:0]   r_qn;
    logic                w_full, w_push, w_head_v;
    pend_t               w_head;
    logic [15:0]         w_new_due, w_diff;
    logic                w_late, w_due1, w_due2;
    state_t              r_state, w_state_nxt;
    logic                w_load, w_collide, w_last;
    logic                r_b_rd, r_b_bl8;
    logic [1:0]          r_b_bg, r_b_ba;
    logic [c_COLH_W-1:0] r_b_col;
    logic [2:0]          r_beat;
    logic [MEM_AW-1:0]   w_maddr;
    logic [DATA_W-1:0]   r_mem [2**MEM_AW];

    assign w_pins = {act_n, ras_n, cas_n, we_n};
    assign w_bank = {bg, ba};

`ifdef DDR_RESP_PARITY_EN
    logic w_par_bad;
    logic r_alert_n;
    assign w_par_bad = !cs_n && ((^{act_n, ras_n, cas_n, we_n, bg, ba, addr}) != par);
    assign w_cmd_en  = !cs_n && !w_par_bad;

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) r_alert_n <= 1'b1;
        else          r_alert_n <= !w_par_bad;
    end
    assign alert_n = r_alert_n;
`else
    logic w_unused_par;
    assign w_unused_par = par;
    assign w_cmd_en     = !cs_n;
    assign alert_n      = 1'b1;
`endif

    assign w_act = w_cmd_en && !act_n;
    assign w_mrs = w_cmd_en && (w_pins == 4'b1000);
    assign w_ref = w_cmd_en && (w_pins == 4'b1001);
    assign w_pre = w_cmd_en && (w_pins == 4'b1010);
    assign w_wr  = w_cmd_en && (w_pins == 4'b1100);
    assign w_rd  = w_cmd_en && (w_pins == 4'b1101);
    assign w_cas = w_wr || w_rd;

    // A CAS to a closed bank proceeds as if row 0 were open.
    assign w_cas_row = r_open[w_bank] ? r_row[w_bank] : 18'd0;
    logic w_unused_row;
    assign w_unused_row = (^w_cas_row) ^ r_wpre;

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) r_cnt <= '0;
        else          r_cnt <= r_cnt + 16'd1;
    end

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            r_open <= '0;
            for (int i = 0; i < 16; i++) r_row[i] <= '0;
            r_cl   <= 5'd9;
            r_cwl  <= 5'd9;
            r_al   <= 5'd0;
            r_bl8  <= 1'b1;
            r_rpre <= 1'b0;
            r_wpre <= 1'b0;
        end else begin
            if (w_act) begin
                r_open[w_bank] <= 1'b1;
                r_row[w_bank]  <= addr;
            end
            if (w_pre) begin
                if (addr[10]) r_open         <= '0;
                else          r_open[w_bank] <= 1'b0;
            end
            if (w_mrs) begin
                case (addr[17:15])
                    3'd0: begin
                        if (addr[6:3] < 4'd12) r_cl <= 5'd9 + {1'b0, addr[6:3]};
                        r_bl8 <= (addr[1:0] != 2'd2);
                    end
                    3'd1: r_al <= (addr[4:3] == 2'd1 || addr[4:3] == 2'd2) ?
                                  r_cl - {3'b000, addr[4:3]} : 5'd0;
                    // The 3-bit CWL field can never exceed the legal range.
                    3'd2: r_cwl <= 5'd9 + {2'b00, addr[5:3]};
                    3'd4: begin
                        r_rpre <= addr[11];
                        r_wpre <= addr[12];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign w_full    = (r_qn == c_QN_FULL);
    assign w_push    = w_cas && !w_full;
    assign w_head_v  = (r_qn != '0);
    assign w_head    = r_q[r_rp];
    assign w_new_due = r_cnt + 16'(w_rd ? r_cl : r_cwl) + 16'(r_al);

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            r_wp <= '0;
            r_rp <= '0;
            r_qn <= '0;
            for (int i = 0; i < PEND_D; i++) r_q[i] <= '0;
        end else begin
            if (w_push) begin
                r_q[r_wp].due <= w_new_due;
                r_q[r_wp].rw  <= w_rd;
                r_q[r_wp].bg  <= bg;
                r_q[r_wp].ba  <= ba;
                r_q[r_wp].col <= addr[COL_IDX_W-1:3];
                r_q[r_wp].bl8 <= r_bl8;
                r_wp <= (r_wp == c_PTR_LAST) ? '0 : r_wp + 1'b1;
            end
            if (w_load) r_rp <= (r_rp == c_PTR_LAST) ? '0 : r_rp + 1'b1;
            case ({w_push, w_load})
                2'b10:   r_qn <= r_qn + 1'b1;
                2'b01:   r_qn <= r_qn - 1'b1;
                default: ;
            endcase
        end
    end

    // Signed distance tolerates heads whose due cycle passed while queued.
    assign w_diff = w_head.due - r_cnt;
    assign w_late = w_head_v && ($signed(w_diff) <= 16'sd0);
    assign w_due1 = w_head_v && (w_diff == 16'd1);
    assign w_due2 = w_head_v && (w_diff == 16'd2);
    assign w_last = (r_beat == (r_b_bl8 ? 3'd7 : 3'd3));
    assign w_maddr = MEM_AW'({r_b_bg, r_b_ba, r_b_col, r_beat});

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_collide   = 1'b0;
        dq_oe       = 1'b0;
        rd_pre      = 1'b0;
        dq_out      = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_late || w_due1) begin
                    w_state_nxt = ST_BURST;
                    w_load      = 1'b1;
                end else if (w_due2) begin
                    w_state_nxt = ST_PRE;
                end
            end
            ST_PRE: begin
                rd_pre      = r_rpre && w_head_v && w_head.rw;
                w_load      = w_head_v;
                w_state_nxt = w_head_v ? ST_BURST : ST_IDLE;
            end
            ST_BURST: begin
                dq_oe     = r_b_rd;
                dq_out    = r_b_rd ? r_mem[w_maddr] : '0;
                w_collide = w_late;
                if (w_last) begin
                    if (w_late || w_due1) w_load      = 1'b1;
                    else if (w_due2)      w_state_nxt = ST_PRE;
                    else                  w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            r_b_rd  <= 1'b0;
            r_b_bl8 <= 1'b1;
            r_b_bg  <= '0;
            r_b_ba  <= '0;
            r_b_col <= '0;
            r_beat  <= '0;
        end else if (w_load) begin
            r_b_rd  <= w_head.rw;
            r_b_bl8 <= w_head.bl8;
            r_b_bg  <= w_head.bg;
            r_b_ba  <= w_head.ba;
            r_b_col <= w_head.col;
            r_beat  <= '0;
        end else if (r_state == ST_BURST) begin
            r_beat <= r_beat + 3'd1;
        end
    end

    always_ff @(posedge clock_t) begin
        if (r_state == ST_BURST && !r_b_rd) r_mem[w_maddr] <= dq_in;
    end

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= '0;
        end else begin
            if (w_cas && !r_open[w_bank])                       r_err[0] <= 1'b1;
            if ((w_act && r_open[w_bank]) || (w_ref && |r_open)) r_err[1] <= 1'b1;
            if (w_cas && w_full)                                 r_err[2] <= 1'b1;
            if (w_collide)                                       r_err[3] <= 1'b1;
        end
    end

    assign cl  = r_cl;
    assign cwl = r_cwl;
    assign al  = r_al;
    assign bl  = r_bl8 ? 4'd8 : 4'd4;
    assign err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ddr_cmd_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ddr_cmd_responder                                         |
// | Description : Self-checking bench: MRS vector table plus scoreboarded      |
// |               burst sequences for ddr_cmd_responder.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ddr_cmd_responder;

    localparam logic [3:0] c_ACT = 4'b0111;
    localparam logic [3:0] c_MRS = 4'b1000;
    localparam logic [3:0] c_WR  = 4'b1100;
    localparam logic [3:0] c_RD  = 4'b1101;

    logic        clock_t = 1'b0;
    logic        reset_n;
    logic        cs_n, act_n, ras_n, cas_n, we_n, par;
    logic [1:0]  bg, ba;
    logic [17:0] addr;
    logic [63:0] dq_in, dq_out;
    logic        dq_oe, rd_pre, alert_n;
    logic [4:0]  cl, cwl, al;
    logic [3:0]  bl, err;

    typedef struct {
        int          cyc;
        logic [63:0] data;
        bit          dc;
    } beat_t;

    typedef struct {
        logic [17:0] a;
        logic [4:0]  cl, cwl, al;
        logic [3:0]  bl;
    } mr_vec_t;

    beat_t   exp_q[$];
    int      pre_q[$];
    beat_t   mon_e;
    int      mon_p;
    int      tb_cyc;
    int      n_tests = 0;
    int      n_fail  = 0;
    mr_vec_t tv[10];

    ddr_cmd_responder dut (
        .clock_t (clock_t),
        .reset_n (reset_n),
        .cs_n    (cs_n),
        .act_n   (act_n),
        .ras_n   (ras_n),
        .cas_n   (cas_n),
        .we_n    (we_n),
        .bg      (bg),
        .ba      (ba),
        .addr    (addr),
        .par     (par),
        .dq_in   (dq_in),
        .dq_out  (dq_out),
        .dq_oe   (dq_oe),
        .rd_pre  (rd_pre),
        .cl      (cl),
        .cwl     (cwl),
        .al      (al),
        .bl      (bl),
        .err     (err),
        .alert_n (alert_n)
    );

    always #5 clock_t = ~clock_t;

    always @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) tb_cyc <= 0;
        else          tb_cyc <= tb_cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, tb_cyc);
        end
    endtask

    task automatic fail(input string msg);
        n_tests++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", msg, tb_cyc);
    endtask

    task automatic step();
        @(posedge clock_t);
        #1;
    endtask

    task automatic cmd(input logic [3:0] pins, input logic [1:0] g, input logic [1:0] b,
                       input logic [17:0] a, input logic bad);
        cs_n = 1'b0;
        {act_n, ras_n, cas_n, we_n} = pins;
        bg = g; ba = b; addr = a;
        par = (^{pins, g, b, a}) ^ bad;
        step();
        cs_n = 1'b1;
        {act_n, ras_n, cas_n, we_n} = 4'hF;
    endtask

    task automatic push_burst(input int start, input int n, input bit dc);
        beat_t e;
        for (int k = 0; k < n; k++) begin
            e.cyc  = start + k;
            e.data = 64'(k % 8);
            e.dc   = dc;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || pre_q.size() != 0) && k < 200) begin
            step();
            k++;
        end
        check({name, "_drained"}, 64'(exp_q.size() + pre_q.size()), 64'd0);
        exp_q.delete();
        pre_q.delete();
    endtask

    // Scoreboard: every read beat and preamble must match its queued expectation.
    always @(negedge clock_t) begin
        if (reset_n) begin
            if (dq_oe) begin
                if (exp_q.size() == 0) begin
                    fail($sformatf("unexpected_beat got dq_oe=1 data=0x%0h required dq_oe=0", dq_out));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat_cycle", 64'(tb_cyc), 64'(mon_e.cyc));
                    if (!mon_e.dc) check("beat_data", dq_out, mon_e.data);
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= tb_cyc) begin
                mon_e = exp_q.pop_front();
                fail($sformatf("missing_beat got dq_oe=0 required beat for cycle %0d", mon_e.cyc));
            end
            if (rd_pre) begin
                if (pre_q.size() == 0) begin
                    fail("unexpected_rd_pre got 1 required 0");
                end else begin
                    mon_p = pre_q.pop_front();
                    check("rd_pre_cycle", 64'(tb_cyc), 64'(mon_p));
                end
            end else if (pre_q.size() != 0 && pre_q[0] <= tb_cyc) begin
                mon_p = pre_q.pop_front();
                fail($sformatf("missing_rd_pre got 0 required 1 at cycle %0d", mon_p));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int u, t0, oe_seen;

        tv[0] = '{18'h00010, 5'd11, 5'd9,  5'd0,  4'd8};
        tv[1] = '{18'h08008, 5'd11, 5'd9,  5'd10, 4'd8};
        tv[2] = '{18'h10018, 5'd11, 5'd12, 5'd10, 4'd8};
        tv[3] = '{18'h00062, 5'd11, 5'd12, 5'd10, 4'd4};
        tv[4] = '{18'h08010, 5'd11, 5'd12, 5'd9,  4'd4};
        tv[5] = '{18'h08018, 5'd11, 5'd12, 5'd0,  4'd4};
        tv[6] = '{18'h1FFFF, 5'd11, 5'd12, 5'd0,  4'd4};
        tv[7] = '{18'h00000, 5'd9,  5'd12, 5'd0,  4'd8};
        tv[8] = '{18'h10000, 5'd9,  5'd9,  5'd0,  4'd8};
        tv[9] = '{18'h20800, 5'd9,  5'd9,  5'd0,  4'd8};

        reset_n = 1'b0;
        cs_n = 1'b1; {act_n, ras_n, cas_n, we_n} = 4'hF;
        bg = '0; ba = '0; addr = '0; par = 1'b0; dq_in = '0;
        repeat (3) @(posedge clock_t);
        #1;
        check("reset_dq_oe", 64'(dq_oe), 64'd0);
        check("reset_dq_out", dq_out, 64'd0);
        check("reset_rd_pre", 64'(rd_pre), 64'd0);
        check("reset_lat", 64'({cl, cwl, al, bl}), 64'({5'd9, 5'd9, 5'd0, 4'd8}));
        check("reset_err", 64'(err), 64'd0);
        check("reset_alert_n", 64'(alert_n), 64'd1);
        reset_n = 1'b1;
        step();

        // MRS decode vectors (last one enables read preamble)
        for (int i = 0; i < 10; i++) begin
            cmd(c_MRS, 2'd0, 2'd0, tv[i].a, 1'b0);
            check($sformatf("mrs_vec%0d", i), 64'({cl, cwl, al, bl}),
                  64'({tv[i].cl, tv[i].cwl, tv[i].al, tv[i].bl}));
        end
        check("mrs_err", 64'(err), 64'd0);

        // Write burst then read it back at CL=11
        cmd(c_MRS, 2'd0, 2'd0, 18'h00010, 1'b0);
        cmd(c_ACT, 2'd0, 2'd1, 18'h00155, 1'b0);
        t0 = tb_cyc;
        cmd(c_WR, 2'd0, 2'd1, 18'h00000, 1'b0);
        while (tb_cyc <= t0 + 16) begin
            dq_in = (tb_cyc >= t0 + 9) ? 64'(tb_cyc - t0 - 9) : 64'hDEAD_BEEF_0BAD_F00D;
            step();
        end
        dq_in = 64'hDEAD_BEEF_0BAD_F00D;
        u = tb_cyc;
        cmd(c_RD, 2'd0, 2'd1, 18'h00000, 1'b0);
        push_burst(u + 11, 8, 1'b0);
        pre_q.push_back(u + 10);
        drain("wr_rd");
        check("wr_rd_err", 64'(err), 64'd0);

        // Read from closed bank 3
        u = tb_cyc;
        cmd(c_RD, 2'd0, 2'd3, 18'h00000, 1'b0);
        push_burst(u + 11, 8, 1'b1);
        pre_q.push_back(u + 10);
        check("closed_rd_err", 64'(err), 64'b0001);
        drain("closed_rd");

        // Double ACT to bank 2
        cmd(c_ACT, 2'd0, 2'd2, 18'h00011, 1'b0);
        check("act_once_err", 64'(err), 64'b0001);
        cmd(c_ACT, 2'd0, 2'd2, 18'h00022, 1'b0);
        check("act_twice_err", 64'(err), 64'b0011);

        // Two reads two cycles apart: collision, 16 contiguous beats
        u = tb_cyc;
        cmd(c_RD, 2'd0, 2'd1, 18'h00000, 1'b0);
        step();
        cmd(c_RD, 2'd0, 2'd1, 18'h00000, 1'b0);
        push_burst(u + 11, 16, 1'b0);
        pre_q.push_back(u + 10);
        check("collide_pre_err", 64'(err), 64'b0011);
        drain("collide");
        check("collide_err", 64'(err), 64'b1011);

        // Five back-to-back reads: fifth dropped, four bursts chained
        u = tb_cyc;
        for (int i = 0; i < 5; i++) cmd(c_RD, 2'd0, 2'd1, 18'h00000, 1'b0);
        push_burst(u + 11, 32, 1'b0);
        pre_q.push_back(u + 10);
        check("ovf_err", 64'(err), 64'b1111);
        drain("ovf");

        // Reset in the middle of a read burst
        u = tb_cyc;
        cmd(c_RD, 2'd0, 2'd1, 18'h00000, 1'b0);
        push_burst(u + 11, 3, 1'b0);
        pre_q.push_back(u + 10);
        while (tb_cyc < u + 14) step();
        check("midburst_oe_before", 64'(dq_oe), 64'd1);
        reset_n = 1'b0;
        exp_q.delete();
        pre_q.delete();
        #1;
        check("midburst_oe_reset", 64'(dq_oe), 64'd0);
        check("midburst_dq_reset", dq_out, 64'd0);
        check("midburst_err_reset", 64'(err), 64'd0);
        check("midburst_lat_reset", 64'({cl, cwl, al, bl}), 64'({5'd9, 5'd9, 5'd0, 4'd8}));
        repeat (2) step();
        reset_n = 1'b1;
        oe_seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (dq_oe) oe_seen++;
        end
        check("midburst_no_beats", 64'(oe_seen), 64'd0);

        // Parity: ACT with wrong parity, then read that bank
        cmd(c_ACT, 2'd1, 2'd0, 18'h00033, 1'b1);
`ifdef DDR_RESP_PARITY_EN
        check("par_alert_low", 64'(alert_n), 64'd0);
        step();
        check("par_alert_one_cycle", 64'(alert_n), 64'd1);
        u = tb_cyc;
        cmd(c_RD, 2'd1, 2'd0, 18'h00000, 1'b0);
        check("par_bank_closed_err", 64'(err), 64'b0001);
`else
        check("par_alert_held", 64'(alert_n), 64'd1);
        step();
        check("par_alert_held2", 64'(alert_n), 64'd1);
        u = tb_cyc;
        cmd(c_RD, 2'd1, 2'd0, 18'h00000, 1'b0);
        check("par_ignored_err", 64'(err), 64'd0);
`endif
        push_burst(u + 9, 8, 1'b1);
        drain("par_rd");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
